// File: rtl/prog_instr_mem_pkg.sv
// Shared constants and load-FSM state type for the program instruction memory.
package prog_instr_mem_pkg;
  localparam int IM_DATA_WIDTH = 16;
  localparam int ALU_OPCODE    = 4;
  localparam int IM_ADDR_WIDTH = IM_DATA_WIDTH-ALU_OPCODE-1;

  typedef enum logic [1:0] {IM_IDLE, IM_LOAD, IM_DONE} im_load_state_t;
endpackage

// File: rtl/prog_instr_mem_im_storage.sv
// Single-clock word array: one synchronous write port, one registered read port.
module prog_instr_mem_im_storage #(
  parameter int W     = 16,
  parameter int AW    = 11,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Callers only present addresses < DEPTH, so the upper address bits are redundant.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[IW-1:0]];
  end
endmodule

// File: rtl/prog_instr_mem.sv
// Instruction memory with a handshaked program-load port and a 1-cycle fetch port.
// Optional IM_PARITY_EN: one even-parity bit per word, checked on fetch (fetch_perr).
module prog_instr_mem
  import prog_instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = IM_DATA_WIDTH,
  parameter int ADDR_WIDTH = IM_ADDR_WIDTH,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_stall,
  output logic                  fetch_err,
  output logic                  fetch_perr
);
`ifdef IM_PARITY_EN
  localparam int MW = DATA_WIDTH+1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);
  localparam logic [ADDR_WIDTH:0]   FULL = (ADDR_WIDTH+1)'(DEPTH);

  im_load_state_t        state, nstate;
  logic [ADDR_WIDTH-1:0] wptr, base_mod;
  logic [ADDR_WIDTH:0]   cnt, cnt_inc;
  logic                  acc, fetch_go, addr_ok;
  logic [MW-1:0]         wdata, rdata;

  assign acc      = (state == IM_LOAD) && load_valid;
  assign cnt_inc  = cnt + 1'b1;
  assign base_mod = ADDR_WIDTH'(32'(load_base) % DEPTH);
  assign fetch_go = fetch_req && (state == IM_IDLE);
  assign addr_ok  = {1'b0, fetch_addr} < FULL;

  always_comb begin
    nstate = state;
    case (state)
      IM_IDLE: if (load_start) nstate = IM_LOAD;
      IM_LOAD: if (acc && (load_last || cnt_inc == FULL)) nstate = IM_DONE;
      IM_DONE: nstate = IM_IDLE;
      default: nstate = IM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IM_IDLE;
      wptr        <= '0;
      cnt         <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state <= nstate;
      if (state == IM_IDLE && load_start) begin
        wptr <= base_mod;
        cnt  <= '0;
      end else if (acc) begin
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
        cnt  <= cnt_inc;
      end
      fetch_valid <= fetch_go;
      fetch_err   <= fetch_go && !addr_ok;
    end
  end

  assign load_ready  = (state == IM_LOAD);
  assign load_busy   = (state != IM_IDLE);
  assign load_done   = (state == IM_DONE);
  assign fetch_stall = load_busy;

`ifdef IM_PARITY_EN
  assign wdata = {^load_data, load_data};
`else
  assign wdata = load_data;
`endif

  prog_instr_mem_im_storage #(.W(MW), .AW(ADDR_WIDTH), .DEPTH(DEPTH)) u_im_storage (
    .clk   (clk),
    .we    (acc),
    .waddr (wptr),
    .wdata (wdata),
    .re    (fetch_go && addr_ok),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  // The storage read register has no reset; gating keeps fetch_data at 0 out of reset and on errors.
  assign fetch_data = (fetch_valid && !fetch_err) ? rdata[DATA_WIDTH-1:0] : '0;
`ifdef IM_PARITY_EN
  assign fetch_perr = fetch_valid && !fetch_err && (^rdata);
`else
  assign fetch_perr = 1'b0;
`endif
endmodule

// File: tb/tb_prog_instr_mem.sv
// Directed + randomized bench for prog_instr_mem (DEPTH=8, ADDR_WIDTH=4) against an array model.
module tb_prog_instr_mem;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start, load_valid, load_last, fetch_req;
  logic [AW-1:0] load_base, fetch_addr;
  logic [DW-1:0] load_data;
  logic          load_ready, load_busy, load_done;
  logic          fetch_valid, fetch_stall, fetch_err, fetch_perr;
  logic [DW-1:0] fetch_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [DP];
  bit            known   [DP];
  logic [DW-1:0] wbuf    [16];
  logic [AW-1:0] fb      [16];

  prog_instr_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_stall(fetch_stall), .fetch_err(fetch_err),
    .fetch_perr(fetch_perr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input logic [AW-1:0] a);
    chk($sformatf("fetch_valid[%0d]", a), 32'(fetch_valid), 1);
    if (int'(a) >= DP) begin
      chk($sformatf("fetch_err_oob[%0d]", a), 32'(fetch_err), 1);
      chk($sformatf("fetch_data_oob[%0d]", a), 32'(fetch_data), 0);
    end else begin
      chk($sformatf("fetch_err[%0d]", a), 32'(fetch_err), 0);
      if (known[a]) begin
        chk($sformatf("fetch_data[%0d]", a), 32'(fetch_data), 32'(ref_mem[a]));
        chk($sformatf("fetch_perr[%0d]", a), 32'(fetch_perr), 0);
      end
    end
  endtask

  task automatic fetch_burst(input int n);
    for (int i = 0; i < n; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = fb[i];
      step();
      check_fetch(fb[i]);
    end
    fetch_req = 1'b0;
    step();
    chk("fetch_idle_valid", 32'(fetch_valid), 0);
  endtask

  // gap_mode: 0 always valid, 1 alternate 1/0, 2 random
  task automatic load_session(input logic [AW-1:0] base, input int n, input bit use_last,
                              input int gap_mode, input logic [AW-1:0] fa);
    int  idx, cnt, wp, cyc;
    bit  done, v, lst;
    load_start = 1'b1; load_base = base;
    fetch_req  = 1'b1; fetch_addr = fa;
    step();
    load_start = 1'b0; fetch_req = 1'b0;
    check_fetch(fa);
    chk("start_busy", 32'(load_busy), 1);
    chk("start_ready", 32'(load_ready), 1);
    wp = int'(base) % DP; idx = 0; cnt = 0; done = 0; cyc = 0;
    while (!done && cyc < 64) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      lst        = use_last && (idx == n-1);
      load_valid = v;
      load_data  = wbuf[idx % 16];
      load_last  = lst;
      load_start = ($urandom_range(0, 3) == 0);
      load_base  = AW'($urandom);
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = AW'($urandom);
      chk("stall_in_load", 32'(fetch_stall), 1);
      step();
      chk("fetch_dropped", 32'(fetch_valid), 0);
      if (v) begin
        ref_mem[wp] = wbuf[idx % 16];
        known[wp]   = 1'b1;
        wp  = (wp + 1) % DP;
        cnt++;
        idx++;
        if (lst || cnt == DP) done = 1'b1;
      end
      chk("load_done", 32'(load_done), 32'(done));
      chk("load_ready", 32'(load_ready), 32'(!done));
      cyc++;
    end
    if (!done) chk("load_timeout", 0, 1);
    // DONE cycle: stray valid/start/fetch must all be ignored
    load_valid = 1'b1; load_data = 16'hDEAD; load_last = 1'b0;
    load_start = 1'b1; load_base = AW'($urandom);
    fetch_req  = 1'b1; fetch_addr = '0;
    chk("stall_in_done", 32'(fetch_stall), 1);
    step();
    chk("fetch_dropped_done", 32'(fetch_valid), 0);
    chk("done_one_cycle", 32'(load_done), 0);
    chk("idle_after_done", 32'(load_busy), 0);
    load_valid = 1'b0; load_start = 1'b0; fetch_req = 1'b0;
    step();
    chk("idle_hold", 32'(load_busy), 0);
  endtask

  initial begin
    int n;
    bit ul;
    rst_n = 1'b0;
    load_start = 0; load_base = '0; load_valid = 0; load_data = '0; load_last = 0;
    fetch_req = 0; fetch_addr = '0;
    for (int i = 0; i < DP; i++) known[i] = 1'b0;

    // 1. reset state, first fetch
    #12;
    chk("rst_busy", 32'(load_busy), 0);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_data", 32'(fetch_data), 0);
    chk("rst_err", 32'(fetch_err), 0);
    chk("rst_perr", 32'(fetch_perr), 0);
    chk("rst_stall", 32'(fetch_stall), 0);
    step();
    rst_n = 1'b1;
    step();
    fb[0] = 0;
    fetch_burst(1);
    chk("idle_busy", 32'(load_busy), 0);

    // 2. basic load + back-to-back fetch
    wbuf[0] = 16; wbuf[1] = 22; wbuf[2] = 30;
    load_session(4'd0, 3, 1'b1, 0, 4'd0);
    fb[0] = 0; fb[1] = 1; fb[2] = 2;
    fetch_burst(3);

    // 3. handshake gaps
    for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
    load_session(4'd3, 4, 1'b1, 1, 4'd1);
    for (int i = 0; i < 4; i++) fb[i] = AW'(3 + i);
    fetch_burst(4);

    // 4. wrap / full without last
    for (int i = 0; i < 8; i++) wbuf[i] = DW'(16'hA0 + i);
    load_session(4'd6, 8, 1'b0, 0, 4'd5);
    for (int i = 0; i < 8; i++) fb[i] = AW'(i);
    fetch_burst(8);

    // 5. out-of-range fetches mixed with a valid one
    fb[0] = 9; fb[1] = 15; fb[2] = 7; fb[3] = 8;
    fetch_burst(4);

    // 6. reset mid-load after 2 of 4 words
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(16'h1110 + i);
    load_start = 1'b1; load_base = 4'd2;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = wbuf[i]; load_last = 1'b0;
      step();
      ref_mem[2+i] = wbuf[i];
    end
    load_data = wbuf[2];
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(load_busy), 0);
    chk("midrst_done", 32'(load_done), 0);
    chk("midrst_ready", 32'(load_ready), 0);
    chk("midrst_data", 32'(fetch_data), 0);
    load_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_no_done", 32'(load_done), 0);
      chk("postrst_idle", 32'(load_busy), 0);
    end
    fb[0] = 2; fb[1] = 3; fb[2] = 4;
    fetch_burst(3);

`ifdef IM_PARITY_EN
    // corrupt one stored data bit; parity must flag it
    u_dut.u_im_storage.mem[3][0] = ~u_dut.u_im_storage.mem[3][0];
    fetch_req = 1'b1; fetch_addr = 4'd3;
    step();
    fetch_req = 1'b0;
    chk("perr_flag", 32'(fetch_perr), 1);
    chk("perr_valid", 32'(fetch_valid), 1);
    known[3] = 1'b0;
    fb[0] = 2; fb[1] = 4;
    fetch_burst(2);
`endif

    // 7. randomized sessions and fetch bursts
    for (int s = 0; s < 8; s++) begin
      n  = $urandom_range(1, 8);
      ul = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) wbuf[i] = DW'($urandom);
      load_session(AW'($urandom), n, ul, 2, AW'($urandom));
      for (int i = 0; i < 10; i++) fb[i] = AW'($urandom);
      fetch_burst(10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
